// File: rtl/convertidor_bcd_binario_pkg.sv
// Shared types for the packed-BCD to binary converter.
// Digit type, largest legal digit, FSM states and a power-of-ten helper.
package paquete_bcd;

   typedef logic [3:0] digito_bcd_t;

   localparam digito_bcd_t BCD_MAX = 4'd9;

   typedef enum logic {
      REPOSO,
      CONVIRTIENDO
   } estado_conv_t;

   // 10**n, used only for elaboration-time width checks
   function automatic longint unsigned pot10(input int n);
      longint unsigned r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/convertidor_bcd_binario_if.sv
// Handshake/data bundle of the BCD to binary converter.
// master: inicio, entradaBCD out; slave: salidaBinaria, listo, ocupado, error out.
interface convertidor_bcd_binario_if #(
   parameter int DIGITOS   = 4,
   parameter int ANCHO_BIN = 14
);

   logic                   inicio;
   logic [4*DIGITOS-1:0]   entradaBCD;
   logic [ANCHO_BIN-1:0]   salidaBinaria;
   logic                   listo;
   logic                   ocupado;
   logic                   error;

   modport master (
      output inicio,
      output entradaBCD,
      input  salidaBinaria,
      input  listo,
      input  ocupado,
      input  error
   );

   modport slave (
      input  inicio,
      input  entradaBCD,
      output salidaBinaria,
      output listo,
      output ocupado,
      output error
   );

endinterface

// File: rtl/convertidor_bcd_binario_paso_horner_bcd.sv
// One Horner step: acc_o = acc_i*10 + digito_i, flags digito_i > 9.
// Ports: acc_i, digito_i in; acc_o, digito_invalido_o out (combinational).
module paso_horner_bcd
   import paquete_bcd::*;
#(
   parameter int ANCHO_BIN = 14
) (
   input  logic [ANCHO_BIN-1:0] acc_i,
   input  digito_bcd_t          digito_i,
   output logic [ANCHO_BIN-1:0] acc_o,
   output logic                 digito_invalido_o
);

   localparam int ANCHO_EXT = ANCHO_BIN + 4;

   logic [ANCHO_EXT-1:0] acc_ext;
   logic [ANCHO_EXT-1:0] suma;
   logic [3:0]           alto_unused;

   assign acc_ext = {4'b0000, acc_i};

   // x*10 = x*8 + x*2, evaluated wide and truncated; the
   // width rule on ANCHO_BIN keeps legal results in range
   assign suma = (acc_ext << 3) + (acc_ext << 1)
               + ANCHO_EXT'(digito_i);

   assign {alto_unused, acc_o} = suma;

   assign digito_invalido_o = (digito_i > BCD_MAX);

endmodule

// File: rtl/convertidor_bcd_binario.sv
// Packed-BCD to binary converter, Horner evaluation, one digit per clock, MSD first.
// Ports: clk, rst (sync, active high); bus (slave): inicio, entradaBCD, salidaBinaria, listo, ocupado, error.
module convertidor_bcd_binario
   import paquete_bcd::*;
#(
   parameter int DIGITOS   = 4,
   parameter int ANCHO_BIN = 14
) (
   input logic                      clk,
   input logic                      rst,
   convertidor_bcd_binario_if.slave bus
);

   localparam int IDX_W = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITOS - 1);

   if (DIGITOS < 1) begin : g_chk_dig
      $error("DIGITOS must be at least 1");
   end

   if (ANCHO_BIN < 64 &&
       (64'd1 << ANCHO_BIN) <= pot10(DIGITOS) - 64'd1) begin : g_chk_ancho
      $error("ANCHO_BIN too narrow for DIGITOS");
   end

   estado_conv_t                  estado_q, estado_d;
   digito_bcd_t [DIGITOS-1:0]     bcd_q, bcd_d;
   logic [ANCHO_BIN-1:0]          acc_q, acc_d;
   logic [IDX_W-1:0]              idx_q, idx_d;
   logic                          bad_q, bad_d;
   logic [ANCHO_BIN-1:0]          salida_q, salida_d;
   logic                          listo_q, listo_d;
   logic                          error_q, error_d;

   digito_bcd_t                   digito;
   logic [ANCHO_BIN-1:0]          acc_nuevo;
   logic                          invalido;
   logic                          bad_total;

   assign digito = bcd_q[idx_q];

   paso_horner_bcd #(
      .ANCHO_BIN(ANCHO_BIN)
   ) u_paso (
      .acc_i             (acc_q),
      .digito_i          (digito),
      .acc_o             (acc_nuevo),
      .digito_invalido_o (invalido)
   );

   assign bad_total = bad_q | invalido;

   always_comb begin
      estado_d = estado_q;
      bcd_d    = bcd_q;
      acc_d    = acc_q;
      idx_d    = idx_q;
      bad_d    = bad_q;
      salida_d = salida_q;
      listo_d  = 1'b0;
      error_d  = error_q;
      unique case (estado_q)
         REPOSO: begin
            if (bus.inicio) begin
               bcd_d    = bus.entradaBCD;
               acc_d    = '0;
               idx_d    = IDX_MAX;
               bad_d    = 1'b0;
               error_d  = 1'b0;
               estado_d = CONVIRTIENDO;
            end
         end
         CONVIRTIENDO: begin
            acc_d = acc_nuevo;
            bad_d = bad_total;
            if (idx_q == '0) begin
               // invalid input always yields 0, never a partial value
               salida_d = bad_total ? '0 : acc_nuevo;
               error_d  = bad_total;
               listo_d  = 1'b1;
               estado_d = REPOSO;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
         default: estado_d = REPOSO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q <= REPOSO;
         bcd_q    <= '0;
         acc_q    <= '0;
         idx_q    <= '0;
         bad_q    <= 1'b0;
         salida_q <= '0;
         listo_q  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         estado_q <= estado_d;
         bcd_q    <= bcd_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         bad_q    <= bad_d;
         salida_q <= salida_d;
         listo_q  <= listo_d;
         error_q  <= error_d;
      end
   end

   assign bus.salidaBinaria = salida_q;
   assign bus.listo         = listo_q;
   assign bus.ocupado       = (estado_q == CONVIRTIENDO);
   assign bus.error         = error_q;

endmodule
